// File: rtl/dot_feeder.sv
// dot_feeder: buffers one 216-element window (six beats) and replays it once per output
// channel into a dot_channel, then streams the results out. Watchdog: DOT_FEEDER_TIMEOUT_EN.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module dot_feeder #(
  parameter int N_CS    = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [36*`DATA_LEN-1:0] in_data,
  output logic                    ws_load,
  output logic                    dc_load,
  output logic [3:0]              cs,
  output logic [2:0]              phase,
  output logic [36*`DATA_LEN-1:0] d,
  input  logic                    valid,
  input  logic [`DATA_LEN-1:0]    q,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3:0]              res_cs,
  output logic [`DATA_LEN-1:0]    res_data,
  output logic                    err
);
  localparam int DW = 36*`DATA_LEN;
  localparam logic [3:0] LAST_CH = 4'(N_CS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PEND, S_PRIME, S_RUN, S_WAIT, S_CLEAR, S_DRAIN
  } state_t;

  state_t               state_r, state_s;
  logic [DW-1:0]        buf_r [6];
  logic [2:0]           beat_r, beat_s, k_r, k_s;
  logic [3:0]           ch_r, ch_s;
  logic                 slot_free_s, wr_s, capture_s, tmo_s, done_s;
  logic                 ws_s, dc_s;
  logic [2:0]           phase_s;
  logic [DW-1:0]        d_s;
  logic                 res_valid_s, err_s;
  logic [3:0]           res_cs_s;
  logic [`DATA_LEN-1:0] res_data_s;
`ifdef DOT_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0]        wcnt_r, wcnt_s;
`endif

  // Next-state, result-slot and next-output computation
  always_comb begin
    state_s   = state_r;
    beat_s    = beat_r;
    k_s       = k_r;
    ch_s      = ch_r;
    wr_s      = 1'b0;
    capture_s = 1'b0;
    tmo_s     = 1'b0;
    done_s    = 1'b0;
`ifdef DOT_FEEDER_TIMEOUT_EN
    wcnt_s    = wcnt_r;
`endif
    // The slot is usable next cycle if empty now or being accepted now
    slot_free_s = !res_valid || res_ready;
    case (state_r)
      S_IDLE: begin
        beat_s = 3'd0;
        ch_s   = 4'd0;
        if (start) state_s = S_FILL;
        else       state_s = S_IDLE;
      end
      S_FILL: begin
        if (in_valid) begin
          wr_s = 1'b1;
          if (beat_r == 3'd5) begin
            beat_s  = 3'd0;
            ch_s    = 4'd0;
            state_s = slot_free_s ? S_PRIME : S_PEND;
          end else begin
            beat_s = beat_r + 3'd1;
          end
        end else begin
          state_s = S_FILL;
        end
      end
      S_PEND: begin
        if (slot_free_s) state_s = S_PRIME;
        else             state_s = S_PEND;
      end
      S_PRIME: begin
        k_s     = 3'd0;
        state_s = S_RUN;
      end
      S_RUN: begin
        if (valid) begin
          capture_s = 1'b1;
          state_s   = S_CLEAR;
        end else if (k_r == 3'd5) begin
          state_s = S_WAIT;
`ifdef DOT_FEEDER_TIMEOUT_EN
          wcnt_s  = {TW{1'b0}};
`endif
        end else begin
          k_s = k_r + 3'd1;
        end
      end
      S_WAIT: begin
        if (valid) begin
          capture_s = 1'b1;
          state_s   = S_CLEAR;
        end else begin
`ifdef DOT_FEEDER_TIMEOUT_EN
          if (wcnt_r == TW'(TIMEOUT-1)) begin
            tmo_s   = 1'b1;
            state_s = S_CLEAR;
          end else begin
            wcnt_s = wcnt_r + {{(TW-1){1'b0}}, 1'b1};
          end
`else
          state_s = S_WAIT;
`endif
        end
      end
      S_CLEAR: begin
        if (ch_r == LAST_CH) begin
          state_s = S_DRAIN;
        end else begin
          ch_s    = ch_r + 4'd1;
          state_s = slot_free_s ? S_PRIME : S_PEND;
        end
      end
      S_DRAIN: begin
        if (slot_free_s) begin
          done_s  = 1'b1;
          ch_s    = 4'd0;
          state_s = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: state_s = S_IDLE;
    endcase

    ws_s    = 1'b0;
    dc_s    = 1'b0;
    phase_s = 3'd0;
    d_s     = {DW{1'b0}};
    case (state_s)
      S_PRIME: ws_s = 1'b1;
      S_RUN: begin
        // phase leads d by one cycle for the weight-store read latency
        ws_s    = 1'b1;
        dc_s    = 1'b1;
        phase_s = (k_s == 3'd5) ? 3'd5 : (k_s + 3'd1);
        d_s     = buf_r[k_s];
      end
      S_WAIT: begin
        ws_s    = 1'b1;
        dc_s    = 1'b1;
        phase_s = 3'd5;
      end
      default: ws_s = 1'b0;
    endcase

    if (capture_s) begin
      res_valid_s = 1'b1;
      res_cs_s    = ch_r;
      res_data_s  = q;
    end else if (tmo_s) begin
      res_valid_s = 1'b1;
      res_cs_s    = ch_r;
      res_data_s  = {`DATA_LEN{1'b0}};
    end else if (res_valid && res_ready) begin
      res_valid_s = 1'b0;
      res_cs_s    = res_cs;
      res_data_s  = res_data;
    end else begin
      res_valid_s = res_valid;
      res_cs_s    = res_cs;
      res_data_s  = res_data;
    end
`ifdef DOT_FEEDER_TIMEOUT_EN
    err_s = err | tmo_s;
`else
    err_s = 1'b0;
`endif
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      beat_r    <= 3'd0;
      k_r       <= 3'd0;
      ch_r      <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      ws_load   <= 1'b0;
      dc_load   <= 1'b0;
      cs        <= 4'd0;
      phase     <= 3'd0;
      d         <= {DW{1'b0}};
      res_valid <= 1'b0;
      res_cs    <= 4'd0;
      res_data  <= {`DATA_LEN{1'b0}};
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      beat_r    <= beat_s;
      k_r       <= k_s;
      ch_r      <= ch_s;
      busy      <= (state_s != S_IDLE);
      done      <= done_s;
      in_ready  <= (state_s == S_FILL);
      ws_load   <= ws_s;
      dc_load   <= dc_s;
      cs        <= ch_s;
      phase     <= phase_s;
      d         <= d_s;
      res_valid <= res_valid_s;
      res_cs    <= res_cs_s;
      res_data  <= res_data_s;
      err       <= err_s;
    end
  end

`ifdef DOT_FEEDER_TIMEOUT_EN
  // WAIT-cycle watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt_r <= {TW{1'b0}};
    else        wcnt_r <= wcnt_s;
  end
`endif

  // Window buffer; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_s) buf_r[beat_r] <= in_data;
  end
endmodule

// File: tb/tb_dot_feeder.sv
// Directed self-checking bench for dot_feeder (N_CS=2, TIMEOUT=8) with a small dot_channel model.
`timescale 1ns/1ps
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_dot_feeder;
  localparam int DL      = `DATA_LEN;
  localparam int DW      = 36*DL;
  localparam int N_CS    = 2;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic          valid = 1'b0, res_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DL-1:0] q = '0;
  logic          busy, done, in_ready, ws_load, dc_load, res_valid, err;
  logic [3:0]    cs, res_cs;
  logic [2:0]    phase;
  logic [DW-1:0] d;
  logic [DL-1:0] res_data;

  int checks = 0;
  int errors = 0;

  // channel model: accumulates d while dc_load, strobes valid chan_delay cycles into WAIT
  int            pc = 0;
  int            chan_delay = 3;
  bit            chan_en = 1'b1;
  logic [DL-1:0] acc = '0;

  dot_feeder #(.N_CS(N_CS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ws_load(ws_load), .dc_load(dc_load), .cs(cs), .phase(phase), .d(d),
    .valid(valid), .q(q), .res_valid(res_valid), .res_ready(res_ready),
    .res_cs(res_cs), .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ws_load && dc_load) begin
      pc = pc + 1;
      for (int e = 0; e < 36; e++) acc = acc + d[e*DL +: DL];
      q     = acc;
      valid = chan_en && (pc == 6 + chan_delay);
    end else begin
      pc    = 0;
      acc   = '0;
      valid = 1'b0;
    end
  end

  task automatic start_window();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic fill(input int step);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = {36{DL'(1 + k*step)}};
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({busy, done, in_ready, ws_load, dc_load, res_valid, err} !== 7'b0) begin errors++; $display("FAIL reset_flags got %b want 0", {busy, done, in_ready, ws_load, dc_load, res_valid, err}); end
    checks++; if ({cs, phase, res_cs} !== 11'b0) begin errors++; $display("FAIL reset_fields got %h want 0", {cs, phase, res_cs}); end
    checks++; if (d !== '0 || res_data !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 0", d, res_data); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_window();
    int exp_ph [7] = '{0, 1, 2, 3, 4, 5, 5};
    int ws_cnt = 0, dc_cnt = 0, nres = 0, ndone = 0, cyc = 0, ph_idx = -1;
    res_ready = 1'b1; chan_en = 1'b1; chan_delay = 3;
    start_window();
    fill(0);
    while (cyc < 100 && ndone == 0) begin
      if (ws_load) ws_cnt++;
      if (dc_load) dc_cnt++;
      if (ws_load && !dc_load) ph_idx = 0;
      if (ph_idx >= 0 && ph_idx < 7) begin
        checks++; if (phase !== 3'(exp_ph[ph_idx])) begin errors++; $display("FAIL win_phase idx %0d got %0d want %0d", ph_idx, phase, exp_ph[ph_idx]); end
        ph_idx++;
      end
      if (res_valid && res_ready) begin
        checks++; if (res_cs !== 4'(nres) || res_data !== DL'(216)) begin errors++; $display("FAIL win_result got cs=%0d data=%0d want cs=%0d data=216", res_cs, res_data, nres); end
        nres++;
      end
      if (done) ndone++;
      @(negedge clk); cyc++;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL win_done got %0d want 1", ndone); end
    checks++; if (nres !== 2) begin errors++; $display("FAIL win_nres got %0d want 2", nres); end
    checks++; if (ws_cnt !== 20 || dc_cnt !== 18) begin errors++; $display("FAIL win_cycles got ws=%0d dc=%0d want 20/18", ws_cnt, dc_cnt); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL win_after got done=%b busy=%b want 0/0", done, busy); end
`ifndef DOT_FEEDER_TIMEOUT_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL win_err got %b want 0", err); end
`endif
  endtask

  task automatic test_fill_toggle();
    int k = 0, nres = 0, ndone = 0, cyc = 0;
    res_ready = 1'b1;
    start_window();
    for (int c = 0; c < 11; c++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tog_ready c=%0d got %b want 1", c, in_ready); end
      if (c % 2 == 0) begin
        in_valid = 1'b1; in_data = {36{DL'(k + 1)}}; start = 1'b0; k++;
      end else begin
        in_valid = 1'b0; in_data = '1; start = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_data = '0; start = 1'b0;
    checks++; if (in_ready !== 1'b0 || !(ws_load && !dc_load)) begin errors++; $display("FAIL tog_prime got ready=%b ws=%b dc=%b want 0/1/0", in_ready, ws_load, dc_load); end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++; if (d !== {36{DL'(j + 1)}}) begin errors++; $display("FAIL tog_d k=%0d got %h want elements %0d", j, d, j + 1); end
    end
    while (cyc < 100 && ndone == 0) begin
      if (res_valid && res_ready) begin
        checks++; if (res_cs !== 4'(nres) || res_data !== DL'(756)) begin errors++; $display("FAIL tog_result got cs=%0d data=%0d want cs=%0d data=756", res_cs, res_data, nres); end
        nres++;
      end
      if (done) ndone++;
      @(negedge clk); cyc++;
    end
    checks++; if (nres !== 2 || ndone !== 1) begin errors++; $display("FAIL tog_end got nres=%0d done=%0d want 2/1", nres, ndone); end
  endtask

  task automatic test_backpressure();
    int cyc = 0, nres = 0, ndone = 0;
    res_ready = 1'b0;
    start_window();
    fill(0);
    while (!res_valid && cyc < 60) begin @(negedge clk); cyc++; end
    checks++; if (res_valid !== 1'b1 || res_cs !== 4'd0 || res_data !== DL'(216)) begin errors++; $display("FAIL bp_first got v=%b cs=%0d data=%0d want 1/0/216", res_valid, res_cs, res_data); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_cs !== 4'd0 || res_data !== DL'(216) || ws_load !== 1'b0) begin errors++; $display("FAIL bp_hold i=%0d got v=%b cs=%0d data=%0d ws=%b want 1/0/216/0", i, res_valid, res_cs, res_data, ws_load); end
    end
    res_ready = 1'b1;
    cyc = 0;
    while (cyc < 100 && ndone == 0) begin
      if (res_valid && res_ready) begin
        checks++; if (res_cs !== 4'(nres) || res_data !== DL'(216)) begin errors++; $display("FAIL bp_result got cs=%0d data=%0d want cs=%0d data=216", res_cs, res_data, nres); end
        nres++;
      end
      if (done) ndone++;
      @(negedge clk); cyc++;
    end
    checks++; if (nres !== 2 || ndone !== 1) begin errors++; $display("FAIL bp_end got nres=%0d done=%0d want 2/1", nres, ndone); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, ndone = 0;
    bit got = 1'b0;
    res_ready = 1'b1;
    start_window();
    fill(0);
    while (!(dc_load && phase == 3'd4) && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (!(dc_load && phase == 3'd4)) begin errors++; $display("FAIL rst_run3 got dc=%b phase=%0d want 1/4", dc_load, phase); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, in_ready, ws_load, dc_load, res_valid, err} !== 7'b0) begin errors++; $display("FAIL rst_flags got %b want 0", {busy, done, in_ready, ws_load, dc_load, res_valid, err}); end
    checks++; if ({cs, phase, res_cs} !== 11'b0 || d !== '0 || res_data !== '0) begin errors++; $display("FAIL rst_fields got cs=%0d ph=%0d rcs=%0d d=%h rd=%0d want 0", cs, phase, res_cs, d, res_data); end
    @(negedge clk); rst_n = 1'b1;
    start_window();
    fill(0);
    checks++; if (!(ws_load && !dc_load) || cs !== 4'd0) begin errors++; $display("FAIL rst_prime got ws=%b dc=%b cs=%0d want 1/0/0", ws_load, dc_load, cs); end
    cyc = 0;
    while (cyc < 100 && ndone == 0) begin
      if (res_valid && res_ready && !got) begin
        got = 1'b1;
        checks++; if (res_cs !== 4'd0 || res_data !== DL'(216)) begin errors++; $display("FAIL rst_result got cs=%0d data=%0d want 0/216", res_cs, res_data); end
      end
      if (done) ndone++;
      @(negedge clk); cyc++;
    end
    checks++; if (!got || ndone !== 1) begin errors++; $display("FAIL rst_end got res=%b done=%0d want 1/1", got, ndone); end
  endtask

`ifdef DOT_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0, wcnt = 0, ndone = 0;
    chan_en = 1'b0; res_ready = 1'b1;
    start_window();
    fill(0);
    while (!res_valid && cyc < 60) begin
      if (ws_load && dc_load && phase == 3'd5 && d == '0) wcnt++;
      @(negedge clk); cyc++;
    end
    checks++; if (wcnt !== TIMEOUT) begin errors++; $display("FAIL tmo_wait got %0d want %0d", wcnt, TIMEOUT); end
    checks++; if (res_valid !== 1'b1 || res_data !== '0 || res_cs !== 4'd0 || err !== 1'b1) begin errors++; $display("FAIL tmo_result got v=%b data=%0d cs=%0d err=%b want 1/0/0/1", res_valid, res_data, res_cs, err); end
    @(negedge clk);
    checks++; if (!(ws_load && !dc_load) || cs !== 4'd1) begin errors++; $display("FAIL tmo_next got ws=%b dc=%b cs=%0d want 1/0/1", ws_load, dc_load, cs); end
    cyc = 0;
    while (cyc < 100 && ndone == 0) begin
      if (done) ndone++;
      @(negedge clk); cyc++;
    end
    checks++; if (ndone !== 1 || err !== 1'b1) begin errors++; $display("FAIL tmo_end got done=%0d err=%b want 1/1", ndone, err); end
    chan_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_window();
    test_fill_toggle();
    test_backpressure();
    test_reset_mid();
`ifdef DOT_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
